// File: rtl/serial_sign_apply_if.sv
`default_nettype none
// ============================================================================
//  serial_sign_apply_if
//  Request/result bundle for the bit-serial sign-apply converter.
//  Revision: 1.0
// ============================================================================
interface serial_sign_apply_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] mag;
  logic         sign;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;

  modport master (
    output start, mag, sign,
    input  busy, done, result, ovf
  );

  modport slave (
    input  start, mag, sign,
    output busy, done, result, ovf
  );
endinterface
`default_nettype wire

// File: rtl/serial_sign_apply.sv
`default_nettype none
// ============================================================================
//  serial_sign_apply
//  Bit-serial sign-magnitude to two's-complement converter, LSB first, W clocks.
//  Optional build macro: SSA_SAT_EN (saturate the result on overflow).
//  Revision: 1.0
// ============================================================================
module serial_sign_apply #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_sign_apply_if.slave bus
);

  localparam int            CW   = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          sign_q, sign_d;
  logic          ovf_next_q, ovf_next_d;
  logic          ovf_q, ovf_d;

  logic          b;
  logic          out_bit;
  logic [W-1:0]  acc_shift;
  logic          load_ovf;

  // Once a one has passed, every later bit is inverted when negating.
  assign b         = sreg_q[0];
  assign out_bit   = b ^ (flag_q & sign_q);
  assign acc_shift = {out_bit, acc_q[W-1:1]};

  // Negative side can reach -2^(W-1); positive side stops at 2^(W-1)-1.
  assign load_ovf  = bus.sign ? (bus.mag[W-1] & (|bus.mag[W-2:0])) : bus.mag[W-1];

`ifdef SSA_SAT_EN
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
`endif

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    acc_d      = acc_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    flag_d     = flag_q;
    sign_d     = sign_q;
    ovf_next_d = ovf_next_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          state_d    = S_RUN;
          sreg_d     = bus.mag;
          acc_d      = '0;
          sign_d     = bus.sign;
          flag_d     = 1'b0;
          cnt_d      = '0;
          ovf_next_d = load_ovf;
        end
      end
      S_RUN: begin
        acc_d  = acc_shift;
        flag_d = flag_q | b;
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = acc_shift;
          ovf_d    = ovf_next_q;
`ifdef SSA_SAT_EN
          if (ovf_next_q) begin
            result_d = sign_q ? MIN_NEG : MAX_POS;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      sign_q     <= 1'b0;
      ovf_next_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      flag_q     <= flag_d;
      sign_q     <= sign_d;
      ovf_next_q <= ovf_next_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == S_RUN);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_sign_apply.sv
`default_nettype none
// ============================================================================
//  tb_serial_sign_apply
//  Directed and randomized checks of serial_sign_apply against an arithmetic model.
//  Revision: 1.0
// ============================================================================
module tb_serial_sign_apply;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [W-1:0] prev_res;
  logic         prev_ovf;

  serial_sign_apply_if #(.W(W)) bus ();

  serial_sign_apply #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ovf, result} from signed arithmetic on the magnitude
  function automatic logic [W:0] model(input logic [W-1:0] m, input logic s);
    int           mi;
    int           half;
    int           v;
    logic         o;
    logic [W-1:0] r;
    mi   = int'(m);
    half = 1 << (W - 1);
    v    = s ? -mi : mi;
    o    = s ? (mi > half) : (mi >= half);
    r    = v[W-1:0];
`ifdef SSA_SAT_EN
    if (o) r = s ? W'(half) : W'(half - 1);
`endif
    return {o, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int e0, output int e);
    e = e0;
    while (!bus.done && e < 4 * W) begin
      @(negedge clk);
      e++;
    end
  endtask

  // One conversion with random start/mag/sign noise while busy.
  task automatic convert(input logic [W-1:0] m, input logic s,
                         output logic [W-1:0] r, output logic o);
    logic [W:0] exp;
    int         e;
    int         busy_cnt;
    exp = model(m, s);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mag   = m;
    bus.sign  = s;
    @(negedge clk);
    e        = 0;
    busy_cnt = 0;
    while (!bus.done && e < 4 * W) begin
      if (bus.busy) busy_cnt++;
      if (e == W - 1) begin
        check("held_result", 32'(bus.result), 32'(prev_res));
        check("held_ovf", 32'(bus.ovf), 32'(prev_ovf));
      end
      bus.start = (e < W) ? 1'($urandom) : 1'b0;
      bus.mag   = W'($urandom);
      bus.sign  = 1'($urandom);
      @(negedge clk);
      e++;
    end
    bus.start = 1'b0;
    check("latency", 32'(e), 32'(W));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("result", 32'(bus.result), 32'(exp[W-1:0]));
    check("ovf", 32'(bus.ovf), 32'(exp[W]));
    r        = bus.result;
    o        = bus.ovf;
    prev_res = exp[W-1:0];
    prev_ovf = exp[W];
  endtask

  initial begin
    logic [W-1:0] r;
    logic         o;
    logic [W:0]   ea;
    logic [W:0]   eb;
    int           e;
    int           done_cnt;

    tests     = 0;
    fails     = 0;
    prev_res  = '0;
    prev_ovf  = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mag   = '0;
    bus.sign  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;

    // Basic negation, latency and single-cycle done
    convert(8'h05, 1'b1, r, o);
    check("t1_result", 32'(r), 32'h0FB);
    check("t1_ovf", 32'(o), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(bus.done), 32'd0);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);

    // Boundaries
    convert(8'h00, 1'b1, r, o);
    check("neg_zero", 32'({o, r}), 32'h000);
    convert(8'h80, 1'b1, r, o);
    check("most_neg", 32'({o, r}), 32'h080);
    convert(8'h7F, 1'b0, r, o);
    check("most_pos", 32'({o, r}), 32'h07F);
`ifdef SSA_SAT_EN
    convert(8'h81, 1'b1, r, o);
    check("ovf_neg", 32'({o, r}), 32'h180);
    convert(8'hC8, 1'b0, r, o);
    check("ovf_pos", 32'({o, r}), 32'h17F);
`else
    convert(8'h81, 1'b1, r, o);
    check("ovf_neg", 32'({o, r}), 32'h17F);
    convert(8'hC8, 1'b0, r, o);
    check("ovf_pos", 32'({o, r}), 32'h1C8);
`endif

    // Back-to-back with start held and mag changed mid-run
    ea = model(8'h33, 1'b1);
    eb = model(8'h81, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mag   = 8'h33;
    bus.sign  = 1'b1;
    @(negedge clk);
    bus.mag   = 8'h81;
    bus.sign  = 1'b0;
    wait_done(0, e);
    check("b2b_first_latency", 32'(e), 32'(W));
    check("b2b_first_result", 32'({bus.ovf, bus.result}), 32'(ea));
    @(negedge clk);
    bus.start = 1'b0;
    bus.mag   = W'($urandom);
    check("b2b_second_accepted", 32'(bus.busy), 32'd1);
    wait_done(0, e);
    check("b2b_second_latency", 32'(e), 32'(W));
    check("b2b_second_result", 32'({bus.ovf, bus.result}), 32'(eb));
    prev_res = eb[W-1:0];
    prev_ovf = eb[W];

    // Asynchronous reset mid-run
    convert(8'h05, 1'b1, r, o);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mag   = 8'h90;
    bus.sign  = 1'b1;
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    prev_res = '0;
    prev_ovf = 1'b0;

    // Random conversions
    for (int i = 0; i < 40; i++) begin
      convert(W'($urandom), 1'($urandom), r, o);
    end

    // Exhaustive sweep of magnitude and sign
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < (1 << W); m++) begin
        convert(W'(m), 1'(s), r, o);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
